dmp_ctrl: RTL and testbench
===========================

# dmp_ctrl

Configuration and domain-sequencing front end for the PMP/DMP checker. It holds the per-entry DMP configuration registers, written through a CSR-style port, and the current execution domain. It drives both into `pmp` as `dmpconf_i` and `expdom_i`. Domain switches are fenced: in-flight memory accesses drain before the new domain becomes visible to the checker.

## Interface
- `NR_ENTRIES`, default 16: number of DMP entries; must be a multiple of 8 and at least 8.
- `XLEN`, default 64: CSR data width; each CSR word holds 8 entries of 8 bits.
- `MAX_OUTSTANDING`, default 8: capacity of the in-flight access counter.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `csr_we_i`  in  1  write strobe for one CSR word.
- `csr_idx_i`  in  CSR_IDX_W = max(1, clog2(NR_ENTRIES/8))  CSR word index.
- `csr_wdata_i`  in  XLEN  write data; byte k configures entry idx*8+k.
- `csr_rdata_o`  out  XLEN  combinational read of word `csr_idx_i`.
- `switch_req_i`  in  1  single-cycle domain-switch request pulse.
- `switch_dom_i`  in  2  target domain (`dmp_domain_t`).
- `switch_busy_o`  out  1  FSM not in IDLE.
- `switch_ack_o`  out  1  one-cycle pulse; the new domain is on `expdom_o` in the same cycle.
- `mem_issue_i`  in  1  a memory access entered flight.
- `mem_retire_i`  in  1  a memory access completed.
- `stall_o`  out  1  block new memory issue.
- `err_o`  out  1  sticky counter overflow/underflow flag.
- `expdom_o`  out  2  current domain, to `pmp.expdom_i`.
- `dmpconf_o`  out  NR_ENTRIES x `dmpcfg_t`  to `pmp.dmpconf_i`.

## Operation
- Domain encoding: DOM0=0, DOM1=1, DOM2=2, DOMI=3.
- Entry byte layout: [1:0] domain, [6:2] reserved, [7] lock.
  - Reserved bits are WARL: writes are dropped and reads return zero.
- CSR write with `csr_we_i` high: every targeted entry updates at the next edge unless it is locked.
  - An out-of-range `csr_idx_i` ignores the write and reads as zero.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - Issue alone: +1.
  - Retire alone: -1.
  - Issue and retire together: unchanged.
  - Issue at MAX_OUTSTANDING: the count saturates and `err_o` sets.
  - Retire at 0: the count stays 0 and `err_o` sets.
  - `err_o` clears only on reset.
- FSM states IDLE, DRAIN, COMMIT.
  - IDLE: on `switch_req_i`, latch `switch_dom_i` into the target register and go to DRAIN. Requests are sampled only in IDLE; requests arriving while busy are dropped.
  - DRAIN: if the next count is 0 (this cycle's retire included), load `expdom` with the target and go to COMMIT; otherwise stay in DRAIN. Issues during DRAIN are still counted.
  - COMMIT: `switch_ack_o` is 1; return to IDLE.
- `stall_o` = state != IDLE.
- A switch to the current domain takes the full sequence and is still acked.
- A CSR write during a switch is allowed and independent of the FSM.

## Timing
- Reset values: `expdom_o` = DOMI, all entries = DOMI with lock 0, counter 0, state IDLE.
  - `switch_ack_o`, `switch_busy_o`, `stall_o` and `err_o` are all 0.
- CSR write takes effect one cycle later, on `dmpconf_o` and `csr_rdata_o`.
- Switch latency:
  - Request accepted at cycle n with count 0: DRAIN at n+1, ack and new `expdom_o` at n+2.
  - With k accesses outstanding: the ack comes 1 cycle after the cycle in which the last retire arrives.
- `expdom_o` never changes outside a COMMIT entry or reset.
- Reset asserted mid-switch: immediate return to reset values; no ack is issued and the request is lost.

## Configuration
- `DMP_LOCK_EN` defined:
  - Bit 7 is a lock bit; once written 1, the entry ignores all writes until reset.
  - The lock bit reads back 1.
  - A write that sets lock also applies its domain field in the same write.
- `DMP_LOCK_EN` undefined:
  - Bit 7 is reserved and reads zero.
  - All in-range writes take effect.

## Structure
- Shared package (`riscv`): `dmp_domain_t` and its encodings, `dmpcfg_t`, `DMP_ENTRIES_PER_CSR` = 8.
- Sub-module `dmp_outstanding_cnt` (parameter MAX_OUTSTANDING): the saturating counter plus error flag; outputs `zero_next_o` for the FSM.

## Test plan
- Reset, then read idx 0 -> `csr_rdata_o` = 0x0303030303030303, `expdom_o` = 3.
- Write idx 0 with 0x...0001 -> entry 0 = DOM1 one cycle later; reserved bits written as 0xFC read back 0.
- Switch to DOM0 with count 0 at cycle n -> ack and `expdom_o` = 0 at n+2, `stall_o` high at n+1 and n+2.
- 3 issues, then switch to DOM2, retires at +4, +6 and +9 cycles -> ack exactly 1 cycle after the third retire; a second request during DRAIN is dropped.
- 9 issues with MAX_OUTSTANDING=8 -> count stays 8 and `err_o` = 1; a retire at 0 also sets `err_o`.
- With `DMP_LOCK_EN`: write entry 2 = 0x81, then write entry 2 = 0x02 -> entry 2 stays DOM1 with lock set; assert reset mid-DRAIN -> no ack, `expdom_o` = DOMI.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared DMP types: domain encoding, per-entry config byte, domain-switch FSM states.
package riscv;

  typedef enum logic [1:0] {
    DOM0 = 2'd0,
    DOM1 = 2'd1,
    DOM2 = 2'd2,
    DOMI = 2'd3
  } dmp_domain_t;

  // One config byte per entry: [7] lock, [6:2] reserved (read as zero), [1:0] domain.
  typedef struct packed {
    logic        lock;
    logic [4:0]  rsvd;
    dmp_domain_t dom;
  } dmpcfg_t;

  localparam int DMP_ENTRIES_PER_CSR = 8;

  typedef enum logic [1:0] {
    SW_IDLE   = 2'd0,
    SW_DRAIN  = 2'd1,
    SW_COMMIT = 2'd2
  } dmp_sw_state_t;

endpackage

// File: rtl/dmp_outstanding_cnt.sv
// Saturating in-flight memory access counter with a sticky overflow/underflow flag.
// zero_next_o looks ahead one edge so the switch FSM can commit on the last retire.
module dmp_outstanding_cnt #(
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic issue_i,
  input  logic retire_i,
  output logic zero_next_o,
  output logic err_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             err_q;
  logic             err_next;

  always_comb begin
    cnt_next = cnt_q;
    err_next = err_q;
    if (issue_i && !retire_i) begin
      if (cnt_q == CNT_W'(MAX_OUTSTANDING)) begin
        err_next = 1'b1;
      end else begin
        cnt_next = cnt_q + 1'b1;
      end
    end else if (retire_i && !issue_i) begin
      if (cnt_q == '0) begin
        err_next = 1'b1;
      end else begin
        cnt_next = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      err_q <= err_next;
    end
  end

  assign zero_next_o = (cnt_next == '0);
  assign err_o       = err_q;

endmodule

// File: rtl/dmp_ctrl.sv
// DMP configuration registers plus fenced execution-domain switching for the PMP/DMP checker.
// Optional feature: define DMP_LOCK_EN to make config bit 7 a sticky per-entry lock.
module dmp_ctrl
  import riscv::*;
#(
  parameter int NR_ENTRIES      = 16,
  parameter int XLEN            = 64,
  parameter int MAX_OUTSTANDING = 8,
  localparam int N_CSR          = NR_ENTRIES / DMP_ENTRIES_PER_CSR,
  localparam int CSR_IDX_W      = (N_CSR > 1) ? $clog2(N_CSR) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      csr_we_i,
  input  logic [CSR_IDX_W-1:0]      csr_idx_i,
  input  logic [XLEN-1:0]           csr_wdata_i,
  output logic [XLEN-1:0]           csr_rdata_o,
  input  logic                      switch_req_i,
  input  logic [1:0]                switch_dom_i,
  output logic                      switch_busy_o,
  output logic                      switch_ack_o,
  input  logic                      mem_issue_i,
  input  logic                      mem_retire_i,
  output logic                      stall_o,
  output logic                      err_o,
  output logic [1:0]                expdom_o,
  output dmpcfg_t [NR_ENTRIES-1:0]  dmpconf_o
);

  // Reserved and (without locking) bit 7 of each byte are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^csr_wdata_i;

  logic [XLEN-1:0] rd_acc [NR_ENTRIES+1];
  assign rd_acc[0] = '0;

  for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
    localparam int CSR_SEL = gi / DMP_ENTRIES_PER_CSR;
    localparam int BYTE_SEL = gi % DMP_ENTRIES_PER_CSR;

    logic        hit;
    dmp_domain_t dom_reg;
    logic        lock_reg;

    assign hit = csr_we_i && (csr_idx_i == CSR_IDX_W'(CSR_SEL));

`ifdef DMP_LOCK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        dom_reg  <= DOMI;
        lock_reg <= 1'b0;
      end else if (hit && !lock_reg) begin
        dom_reg  <= dmp_domain_t'(csr_wdata_i[8*BYTE_SEL +: 2]);
        lock_reg <= csr_wdata_i[8*BYTE_SEL + 7];
      end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        dom_reg <= DOMI;
      end else if (hit) begin
        dom_reg <= dmp_domain_t'(csr_wdata_i[8*BYTE_SEL +: 2]);
      end
    end
    assign lock_reg = 1'b0;
`endif

    assign dmpconf_o[gi] = '{lock: lock_reg, rsvd: 5'b0, dom: dom_reg};

    // Out-of-range indices match no entry, so they read as zero.
    assign rd_acc[gi+1] = rd_acc[gi] |
        ((csr_idx_i == CSR_IDX_W'(CSR_SEL)) ? (XLEN'(dmpconf_o[gi]) << (8 * BYTE_SEL)) : '0);
  end

  assign csr_rdata_o = rd_acc[NR_ENTRIES];

  logic cnt_zero_next;

  dmp_outstanding_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .issue_i     (mem_issue_i),
    .retire_i    (mem_retire_i),
    .zero_next_o (cnt_zero_next),
    .err_o       (err_o)
  );

  dmp_sw_state_t state_q;
  dmp_domain_t   target_q;
  dmp_domain_t   expdom_q;
  logic          ack_q;
  logic          busy_q;

  // expdom only moves on the DRAIN->COMMIT edge, after in-flight accesses have drained.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SW_IDLE;
      target_q <= DOMI;
      expdom_q <= DOMI;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        SW_IDLE: begin
          ack_q <= 1'b0;
          if (switch_req_i) begin
            target_q <= dmp_domain_t'(switch_dom_i);
            state_q  <= SW_DRAIN;
            busy_q   <= 1'b1;
          end
        end
        SW_DRAIN: begin
          if (cnt_zero_next) begin
            expdom_q <= target_q;
            ack_q    <= 1'b1;
            state_q  <= SW_COMMIT;
          end
        end
        SW_COMMIT: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= SW_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= SW_IDLE;
        end
      endcase
    end
  end

  assign switch_ack_o  = ack_q;
  assign switch_busy_o = busy_q;
  assign stall_o       = busy_q;
  assign expdom_o      = expdom_q;

endmodule

// File: tb/tb_dmp_ctrl.sv
// Self-checking bench for dmp_ctrl: CSR vector table, switch scoreboard, counter corners.
module tb_dmp_ctrl;
  import riscv::*;

  localparam int NE = 24;
  localparam int XL = 64;
  localparam int MO = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 csr_we;
  logic [IW-1:0]        csr_idx;
  logic [XL-1:0]        csr_wdata;
  logic [XL-1:0]        csr_rdata;
  logic                 sw_req;
  logic [1:0]           sw_dom;
  logic                 sw_busy;
  logic                 sw_ack;
  logic                 mem_issue;
  logic                 mem_retire;
  logic                 stall;
  logic                 err;
  logic [1:0]           expdom;
  dmpcfg_t [NE-1:0]     dmpconf;

  dmp_ctrl #(
    .NR_ENTRIES(NE),
    .XLEN(XL),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .csr_we_i     (csr_we),
    .csr_idx_i    (csr_idx),
    .csr_wdata_i  (csr_wdata),
    .csr_rdata_o  (csr_rdata),
    .switch_req_i (sw_req),
    .switch_dom_i (sw_dom),
    .switch_busy_o(sw_busy),
    .switch_ack_o (sw_ack),
    .mem_issue_i  (mem_issue),
    .mem_retire_i (mem_retire),
    .stall_o      (stall),
    .err_o        (err),
    .expdom_o     (expdom),
    .dmpconf_o    (dmpconf)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ack_cnt   = 0;

  typedef struct {
    logic          we;
    logic [IW-1:0] idx;
    logic [63:0]   wdata;
    logic [63:0]   exp;
  } csr_vec_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic [63:0]   exp;
  } rd_exp_t;

  csr_vec_t   vecs[8];
  rd_exp_t    rd_q[$];
  logic [1:0] sw_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else begin
      pass_cnt++;
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Switch scoreboard: every ack must match a queued, accepted request.
  always @(negedge clk) begin
    if (rst_n && sw_ack) begin
      ack_cnt++;
      if (sw_q.size() == 0) begin
        total_cnt++;
        $display("FAIL ack_unexpected: got ack with expdom %0d, required no ack", expdom);
      end else begin
        chk("ack_dom", 64'(expdom), 64'(sw_q.pop_front()));
      end
    end
  end

  task automatic csr_write_read(input string name, input logic [IW-1:0] idx,
                                input logic [63:0] wdata, input logic [63:0] exp);
    csr_we = 1'b1; csr_idx = idx; csr_wdata = wdata;
    @(negedge clk);
    csr_we = 1'b0;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; csr_we = 1'b0; csr_idx = '0; csr_wdata = '0;
    sw_req = 1'b0; sw_dom = 2'd0; mem_issue = 1'b0; mem_retire = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rdata0", csr_rdata, 64'h0303030303030303);
    chk("rst_expdom", 64'(expdom), 64'd3);
    chk("rst_busy", 64'(sw_busy), 64'd0);
    chk("rst_ack", 64'(sw_ack), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    csr_idx = 2'd3; #1;
    chk("rst_rdata3_oor", csr_rdata, 64'h0);

    // CSR table: reserved bits dropped, out-of-range write ignored.
    vecs[0] = '{1'b1, 2'd0, 64'h0000000000000001, 64'h0000000000000001};
    vecs[1] = '{1'b1, 2'd0, 64'h7C7D7E7F7C7D7E7F, 64'h0001020300010203};
    vecs[2] = '{1'b1, 2'd1, 64'h0102030001020300, 64'h0102030001020300};
    vecs[3] = '{1'b1, 2'd2, 64'h0000000000000002, 64'h0000000000000002};
    vecs[4] = '{1'b1, 2'd3, 64'h0101010101010101, 64'h0000000000000000};
    vecs[5] = '{1'b0, 2'd2, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000002};
    vecs[6] = '{1'b0, 2'd0, 64'h0, 64'h0001020300010203};
    vecs[7] = '{1'b0, 2'd1, 64'h0, 64'h0102030001020300};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      csr_we = vecs[i].we; csr_idx = vecs[i].idx; csr_wdata = vecs[i].wdata;
      rd_q.push_back('{vecs[i].idx, vecs[i].exp});
      @(negedge clk);
      csr_we = 1'b0;
      begin
        rd_exp_t e;
        e = rd_q.pop_front();
        csr_idx = e.idx;
        #1;
        chk($sformatf("csr_vec%0d", i), csr_rdata, e.exp);
      end
    end
    chk("conf_e0", 64'(dmpconf[0]), 64'h03);
    chk("conf_e9", 64'(dmpconf[9]), 64'h03);
    chk("conf_e16", 64'(dmpconf[16]), 64'h02);

    // Lock bit behaviour on entry 2.
    @(negedge clk);
`ifdef DMP_LOCK_EN
    csr_write_read("lock_set", 2'd0, 64'h0000000000810000, 64'h0000000000810000);
    csr_write_read("lock_hold", 2'd0, 64'h0000000000020000, 64'h0000000000810000);
    chk("lock_conf_e2", 64'(dmpconf[2]), 64'h81);
`else
    csr_write_read("nolock_b7", 2'd0, 64'h0000000000810000, 64'h0000000000010000);
    csr_write_read("nolock_wr", 2'd0, 64'h0000000000020000, 64'h0000000000020000);
    chk("nolock_conf_e2", 64'(dmpconf[2]), 64'h02);
`endif

    // Switch to DOM0 with nothing in flight: ack at n+2.
    @(negedge clk);
    sw_req = 1'b1; sw_dom = 2'd0; sw_q.push_back(2'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      sw_req = 1'b0;
      chk($sformatf("swA_ack_c%0d", c), 64'(sw_ack), 64'(c == 2));
      chk($sformatf("swA_stall_c%0d", c), 64'(stall), 64'(c != 3));
      chk($sformatf("swA_expdom_c%0d", c), 64'(expdom), (c == 1) ? 64'd3 : 64'd0);
    end

    // Three in flight, switch to DOM2, retires at +4/+6/+9, second request dropped.
    mem_issue = 1'b1;
    repeat (3) @(negedge clk);
    mem_issue = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c > 0) chk($sformatf("swB_ack_c%0d", c), 64'(sw_ack), 64'(c == 10));
      if (c == 9) chk("swB_expdom_hold", 64'(expdom), 64'd0);
      sw_req     = (c == 0) || (c == 2);
      sw_dom     = (c == 0) ? 2'd2 : 2'd1;
      mem_retire = (c == 4) || (c == 6) || (c == 9);
      if (c == 0) sw_q.push_back(2'd2);
    end
    sw_req = 1'b0; mem_retire = 1'b0;
    chk("swB_expdom_final", 64'(expdom), 64'd2);
    chk("swB_idle", 64'(sw_busy), 64'd0);

    // Saturation at MAX_OUTSTANDING: 9 issues leave count 8 and set err.
    @(negedge clk);
    mem_issue = 1'b1;
    repeat (8) @(negedge clk);
    chk("ovf_err_at8", 64'(err), 64'd0);
    @(negedge clk);
    chk("ovf_err_at9", 64'(err), 64'd1);
    mem_issue = 1'b0;
    sw_req = 1'b1; sw_dom = 2'd1; sw_q.push_back(2'd1);
    for (int r = 0; r <= 9; r++) begin
      @(negedge clk);
      sw_req = 1'b0;
      if (r > 0) chk($sformatf("ovf_ack_r%0d", r), 64'(sw_ack), 64'(r == 8));
      mem_retire = (r < 8);
    end
    mem_retire = 1'b0;
    chk("ovf_err_sticky", 64'(err), 64'd1);

    // Reset clears err; simultaneous issue+retire at 0 is harmless; lone retire underflows.
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("rst2_err", 64'(err), 64'd0);
    chk("rst2_expdom", 64'(expdom), 64'd3);
    csr_idx = 2'd0; #1;
    chk("rst2_rdata0", csr_rdata, 64'h0303030303030303);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_issue = 1'b1; mem_retire = 1'b1;
    @(negedge clk);
    mem_issue = 1'b0; mem_retire = 1'b0;
    chk("both_at0_err", 64'(err), 64'd0);
    mem_retire = 1'b1;
    @(negedge clk);
    mem_retire = 1'b0;
    chk("udf_err", 64'(err), 64'd1);
    sw_req = 1'b1; sw_dom = 2'd0; sw_q.push_back(2'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      sw_req = 1'b0;
      chk($sformatf("udf_ack_c%0d", c), 64'(sw_ack), 64'(c == 2));
    end

    // Reset in DRAIN: no ack, domain returns to DOMI.
    mem_issue = 1'b1;
    @(negedge clk);
    mem_issue = 1'b0;
    sw_req = 1'b1; sw_dom = 2'd1; sw_q.push_back(2'd1);
    @(negedge clk);
    sw_req = 1'b0;
    chk("rstd_busy", 64'(sw_busy), 64'd1);
    rst_n = 1'b0; #1;
    chk("rstd_expdom", 64'(expdom), 64'd3);
    chk("rstd_busy0", 64'(sw_busy), 64'd0);
    chk("rstd_stall0", 64'(stall), 64'd0);
    sw_q.delete();
    begin
      int acks_before;
      acks_before = ack_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rstd_no_ack", 64'(ack_cnt - acks_before), 64'd0);
      chk("rstd_expdom_after", 64'(expdom), 64'd3);
    end

    chk("sb_empty", 64'(sw_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
